// File: rtl/serial_adder_4u_seq.sv
// Purpose : unsigned WIDTH-bit adder that works through the operands 4 bits per cycle, LSB slice first.
// Latency : WIDTH/4 BUSY cycles after the accepting edge, then the result sits in DONE (out_valid).
// Backpr. : the result is held in DONE until out_ready; a new pair can be accepted in that same cycle.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready + a/b operand handshake;
//           out_valid/out_ready + sum/cout result handshake ({cout,sum} = a+b).
module serial_adder_4u_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NS = WIDTH / 4;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [KW+1:0]    w_base;
  logic [3:0]       w_op_a;
  logic [3:0]       w_op_b;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [3:0]       w_c;
  logic [3:0]       w_slice;
  logic             w_g10, w_p10, w_g32, w_p32, w_g30, w_p30;
  logic             w_c4;

  assign w_last = (r_k == K_LAST);

  // 4-bit Brent-Kung slice: pair-wise group generate/propagate, then the
  // 4-bit group; c3 is filled in from c2 on the way back down the tree.
  always_comb begin
    w_base  = {r_k, 2'b00};
    w_op_a  = r_a[w_base +: 4];
    w_op_b  = r_b[w_base +: 4];
    w_g     = w_op_a & w_op_b;
    w_p     = w_op_a ^ w_op_b;
    w_g10   = w_g[1] | (w_p[1] & w_g[0]);
    w_p10   = w_p[1] & w_p[0];
    w_g32   = w_g[3] | (w_p[3] & w_g[2]);
    w_p32   = w_p[3] & w_p[2];
    w_g30   = w_g32 | (w_p32 & w_g10);
    w_p30   = w_p32 & w_p10;
    w_c[0]  = r_carry;
    w_c[1]  = w_g[0] | (w_p[0] & r_carry);
    w_c[2]  = w_g10 | (w_p10 & r_carry);
    w_c[3]  = w_g[2] | (w_p[2] & w_c[2]);
    w_c4    = w_g30 | (w_p30 & r_carry);
    w_slice = w_p ^ w_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        // Consuming the result frees the block in the same cycle, so a new
        // pair can go straight into BUSY without an IDLE bubble.
        if (out_ready) begin
          w_in_ready  = 1'b1;
          w_state_nxt = in_valid ? BUSY : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Nothing may be accepted on an edge that is going to reset the block.
    if (rst) w_in_ready = 1'b0;
  end

  assign w_accept = in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_k         <= '0;
    end else if (w_accept) begin
      r_a         <= a;
      r_b         <= b;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == BUSY) begin
      r_sum[w_base +: 4] <= w_slice;
      r_carry            <= w_c4;
      r_k                <= r_k + KW'(1);
      if (w_last) begin
        r_cout      <= w_c4;
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder_4u_seq.sv
// Directed and random checks of serial_adder_4u_seq against a plain a+b reference.
module tb_serial_adder_4u_seq;

  localparam int W   = 16;
  localparam int NTX = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  serial_adder_4u_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers one pair, then follows it until out_valid; returns in the DONE
  // cycle with the result still pending.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ordy, input bit scramble, input string tag);
    logic [W:0] exp;
    int n;
    exp = {1'b0, ta} + {1'b0, tb_v};
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = ordy;
    #1;
    chk({tag, "_acc_rdy"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 12) begin
      chk({tag, "_busy_rdy"}, in_ready, 0);
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      end
      cyc();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, n, W/4 + 1);
    chk({tag, "_res"}, {cout, sum}, exp);
  endtask

  initial begin
    logic [W:0] q[$];
    logic [W:0] exp_r;
    logic [W-1:0] hsum;
    logic hcout;
    bit hold;
    int acc_n, res_n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(negedge clk);
    cyc();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    cyc();

    // Full carry ripple through every slice.
    do_txn(16'hFFFF, 16'h0001, 1'b1, 1'b0, "ripple");
    chk("ripple_cout", cout, 1);
    cyc();
    chk("ripple_consumed", out_valid, 0);
    chk("ripple_idle_rdy", in_ready, 1);

    // Result held under backpressure.
    do_txn(16'h1234, 16'h4321, 1'b0, 1'b0, "hold");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      #1;
      chk("hold_vld", out_valid, 1);
      chk("hold_sum", sum, 16'h5555);
      chk("hold_cout", cout, 0);
      chk("hold_rdy", in_ready, 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("hold_release_rdy", in_ready, 1);
    cyc();
    chk("hold_released", out_valid, 0);

    // Back-to-back: second pair accepted in the DONE cycle of the first.
    do_txn(16'h8000, 16'h8000, 1'b1, 1'b0, "b2b_a");
    do_txn(16'h00FF, 16'h0F01, 1'b1, 1'b0, "b2b_b");
    chk("b2b_b_sum", sum, 16'h1000);
    cyc();
    chk("b2b_done_vld", out_valid, 0);
    chk("b2b_idle_rdy", in_ready, 1);

    // Reset in the middle of BUSY drops the operation.
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_rdy", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("midrst_no_result", out_valid, 0);
    end

    // Inputs churning during BUSY must not disturb the latched operands.
    do_txn(16'h0F0F, 16'hF0F1, 1'b1, 1'b1, "churn");
    chk("churn_sum", sum, 0);
    chk("churn_cout", cout, 1);
    cyc();
    chk("churn_consumed", out_valid, 0);

    // Random traffic against a queue of expected sums.
    acc_n = 0; res_n = 0; hold = 1'b0;
    for (int c = 0; c < 60000 && (acc_n < NTX || q.size() != 0); c++) begin
      if (hold) begin
        chk("rnd_hold_vld", out_valid, 1);
        chk("rnd_hold_res", {cout, sum}, {hcout, hsum});
      end
      in_valid  = (acc_n < NTX) && ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        exp_r = 'x;
        if (q.size() != 0) exp_r = q.pop_front();
        chk("rnd_res", {cout, sum}, exp_r);
        res_n++;
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b});
        acc_n++;
      end
      hold  = out_valid && !out_ready;
      hsum  = sum;
      hcout = cout;
      cyc();
    end
    chk("rnd_accepted", acc_n, NTX);
    chk("rnd_results", res_n, NTX);
    chk("rnd_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
